// File: rtl/por_pkg.sv
// Shared types and helpers for the POR trip sequencer.
// Holds the FSM state encoding and the trip-code one-hot decoder.
package por_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    ARMED    = 3'd1,
    DEBOUNCE = 3'd2,
    DELAY    = 3'd3,
    RELEASED = 3'd4
  } por_state_e;

  localparam logic [2:0] TRIP_MAX = 3'd7;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    onehot8 = 8'h01 << code;
  endfunction

endpackage

// File: rtl/por_sync.sv
// Flop-chain synchronizer bringing the asynchronous comparator output into
// the clk domain; all stages clear to 0 on reset.
module por_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/por_trip_seq.sv
// POR trip sequencer: drives the resistor-string mux, debounces the comparator
// and times the reset release. Optional hysteresis via macro POR_HYST_EN.
module por_trip_seq
  import por_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_CYCLES   = 16,
  parameter int DELAY_CYCLES = 1024,
  parameter int CNT_W        =
    $clog2((DEB_CYCLES > DELAY_CYCLES) ? DEB_CYCLES : DELAY_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] otrip,
  input  logic       cmp_out,
  output logic       ena_rstring,
  output logic [7:0] otrip_decoded,
  output logic       porb,
  output logic       por,
  output logic [2:0] state_o
);

  por_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             ena_rstring_q, ena_rstring_d;
  logic [7:0]       otrip_decoded_q, otrip_decoded_d;
  logic             porb_q, porb_d;
  logic             por_q, por_d;
  logic             cmp_s;

  por_sync #(
    .STAGES(SYNC_STAGES)
  ) u_cmp_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cmp_out),
    .q    (cmp_s)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef POR_HYST_EN
  // Latched trip code, so the hysteresis step ignores otrip outside ARMED.
  logic [2:0] trip_q, trip_d;
  logic [2:0] hyst_trip;

  assign hyst_trip = (trip_q == TRIP_MAX) ? TRIP_MAX : trip_q + 3'd1;

  always_comb begin
    trip_d = trip_q;
    if (state_q == OFF || state_q == ARMED || state_d == ARMED) begin
      trip_d = otrip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trip_q <= 3'd0;
    end else begin
      trip_q <= trip_d;
    end
  end
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ena_rstring_d   = ena_rstring_q;
    otrip_decoded_d = otrip_decoded_q;
    porb_d          = porb_q;
    por_d           = por_q;

    if (!ena) begin
      state_d       = OFF;
      cnt_d         = '0;
      ena_rstring_d = 1'b0;
      porb_d        = 1'b0;
      por_d         = 1'b1;
    end else begin
      case (state_q)
        OFF: begin
          state_d         = ARMED;
          cnt_d           = '0;
          ena_rstring_d   = 1'b1;
          otrip_decoded_d = onehot8(otrip);
          porb_d          = 1'b0;
          por_d           = 1'b1;
        end
        ARMED: begin
          otrip_decoded_d = onehot8(otrip);
          if (cmp_s) begin
            state_d = DEBOUNCE;
            cnt_d   = '0;
          end
        end
        DEBOUNCE: begin
          if (!cmp_s) begin
            state_d         = ARMED;
            cnt_d           = '0;
            otrip_decoded_d = onehot8(otrip);
          end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            state_d = DELAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DELAY: begin
          // A comparator drop wins over a completed count in the same cycle.
          if (!cmp_s) begin
            state_d         = ARMED;
            cnt_d           = '0;
            otrip_decoded_d = onehot8(otrip);
          end else if (cnt_q == CNT_W'(DELAY_CYCLES - 1)) begin
            state_d = RELEASED;
            cnt_d   = '0;
            porb_d  = 1'b1;
            por_d   = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASED: begin
          if (!cmp_s) begin
            state_d         = ARMED;
            cnt_d           = '0;
            otrip_decoded_d = onehot8(otrip);
            porb_d          = 1'b0;
            por_d           = 1'b1;
          end
        end
        default: begin
          state_d       = OFF;
          cnt_d         = '0;
          ena_rstring_d = 1'b0;
          porb_d        = 1'b0;
          por_d         = 1'b1;
        end
      endcase
`ifdef POR_HYST_EN
      if (state_d == DELAY || state_d == RELEASED) begin
        otrip_decoded_d = onehot8(hyst_trip);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= OFF;
      cnt_q           <= '0;
      ena_rstring_q   <= 1'b0;
      otrip_decoded_q <= 8'h00;
      porb_q          <= 1'b0;
      por_q           <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ena_rstring_q   <= ena_rstring_d;
      otrip_decoded_q <= otrip_decoded_d;
      porb_q          <= porb_d;
      por_q           <= por_d;
    end
  end

  assign ena_rstring   = ena_rstring_q;
  assign otrip_decoded = otrip_decoded_q;
  assign porb          = porb_q;
  assign por           = por_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_por_trip_seq.sv
// Self-checking bench for por_trip_seq: directed scenarios plus a randomized
// run against a stable-run reference model. Honours POR_HYST_EN when defined.
module tb_por_trip_seq;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DLY  = 8;
  localparam int LAT  = SYNC + 1 + DEB + DLY;
`ifdef POR_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif
  localparam logic [7:0] EXP_HI = HYST ? 8'h10 : 8'h08;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] otrip;
  logic       cmp_out;
  logic       ena_rstring;
  logic [7:0] otrip_decoded;
  logic       porb;
  logic       por;
  logic [2:0] state_o;

  int n_cmp;
  int n_fail;

  por_trip_seq #(
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB),
    .DELAY_CYCLES(DLY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .otrip        (otrip),
    .cmp_out      (cmp_out),
    .ena_rstring  (ena_rstring),
    .otrip_decoded(otrip_decoded),
    .porb         (porb),
    .por          (por),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] trip);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    ena     = 1'b0;
    cmp_out = 1'b0;
    otrip   = trip;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    int i = 0;
    while (state_o !== s && i < max) begin
      tick();
      i++;
    end
    ok = (state_o === s);
  endtask

  task automatic count_to_porb(output int n);
    n = 0;
    while (porb !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ena   = 1'b1;
    cmp_out = 1'b1;
    #2;
    n_cmp += 5;
    if (state_o !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_state got %0d exp 0", state_o); end
    if (ena_rstring !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ena_rstring got %b exp 0", ena_rstring); end
    if (otrip_decoded !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_decoded got %h exp 00", otrip_decoded); end
    if (porb !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_porb got %b exp 0", porb); end
    if (por !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_por got %b exp 1", por); end
  endtask

  task automatic test_power_up();
    int n;
    do_reset(3'd3);
    ena = 1'b1;
    tick();
    n_cmp += 3;
    if (state_o !== 3'd1) begin n_fail++; $display("[TB] FAIL pu_armed got %0d exp 1", state_o); end
    if (ena_rstring !== 1'b1) begin n_fail++; $display("[TB] FAIL pu_ena_rstring got %b exp 1", ena_rstring); end
    if (otrip_decoded !== 8'h08) begin n_fail++; $display("[TB] FAIL pu_decoded got %h exp 08", otrip_decoded); end
    cmp_out = 1'b1;
    n = 0;
    while (porb !== 1'b1 && n < 60) begin
      tick();
      n++;
      n_cmp++;
      if (por !== ~porb) begin n_fail++; $display("[TB] FAIL pu_por_compl got por=%b porb=%b", por, porb); end
    end
    n_cmp++;
    if (n != LAT) begin n_fail++; $display("[TB] FAIL pu_latency got %0d exp %0d", n, LAT); end
  endtask

  task automatic test_debounce_glitch();
    int n;
    do_reset(3'd3);
    ena = 1'b1;
    tick();
    cmp_out = 1'b1;
    tick();
    tick();
    cmp_out = 1'b0;
    tick();
    n_cmp++;
    if (state_o !== 3'd2) begin n_fail++; $display("[TB] FAIL glitch_debounce got %0d exp 2", state_o); end
    tick();
    tick();
    n_cmp += 2;
    if (state_o !== 3'd1) begin n_fail++; $display("[TB] FAIL glitch_back_armed got %0d exp 1", state_o); end
    if (porb !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_porb got %b exp 0", porb); end
    cmp_out = 1'b1;
    count_to_porb(n);
    n_cmp++;
    if (n != LAT) begin n_fail++; $display("[TB] FAIL glitch_retry_latency got %0d exp %0d", n, LAT); end
  endtask

  task automatic test_brownout();
    int n;
    cmp_out = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (porb !== 1'b1) begin n_fail++; $display("[TB] FAIL bo_early_porb got %b exp 1", porb); end
    tick();
    n_cmp += 3;
    if (porb !== 1'b0) begin n_fail++; $display("[TB] FAIL bo_porb got %b exp 0", porb); end
    if (por !== 1'b1) begin n_fail++; $display("[TB] FAIL bo_por got %b exp 1", por); end
    if (state_o !== 3'd1) begin n_fail++; $display("[TB] FAIL bo_state got %0d exp 1", state_o); end
    cmp_out = 1'b1;
    count_to_porb(n);
    n_cmp++;
    if (n != LAT) begin n_fail++; $display("[TB] FAIL bo_recover_latency got %0d exp %0d", n, LAT); end
  endtask

  task automatic test_trip_change();
    bit ok;
    do_reset(3'd3);
    ena = 1'b1;
    tick();
    cmp_out = 1'b1;
    wait_state(3'd3, 40, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("[TB] FAIL tc_reach_delay got %0d exp 3", state_o); end
    otrip = 3'd6;
    tick();
    tick();
    n_cmp++;
    if (otrip_decoded !== EXP_HI) begin n_fail++; $display("[TB] FAIL tc_delay_decoded got %h exp %h", otrip_decoded, EXP_HI); end
    wait_state(3'd4, 40, ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("[TB] FAIL tc_reach_released got %0d exp 4", state_o); end
    if (otrip_decoded !== EXP_HI) begin n_fail++; $display("[TB] FAIL tc_rel_decoded got %h exp %h", otrip_decoded, EXP_HI); end
    cmp_out = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (state_o !== 3'd1) begin n_fail++; $display("[TB] FAIL tc_bo_state got %0d exp 1", state_o); end
    tick();
    n_cmp++;
    if (otrip_decoded !== 8'h40) begin n_fail++; $display("[TB] FAIL tc_armed_decoded got %h exp 40", otrip_decoded); end
  endtask

  task automatic test_enable_and_reset();
    bit ok;
    do_reset(3'd3);
    ena = 1'b1;
    tick();
    cmp_out = 1'b1;
    wait_state(3'd3, 40, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("[TB] FAIL en_reach_delay got %0d exp 3", state_o); end
    ena = 1'b0;
    tick();
    n_cmp += 5;
    if (state_o !== 3'd0) begin n_fail++; $display("[TB] FAIL en_off_state got %0d exp 0", state_o); end
    if (ena_rstring !== 1'b0) begin n_fail++; $display("[TB] FAIL en_off_rstring got %b exp 0", ena_rstring); end
    if (porb !== 1'b0) begin n_fail++; $display("[TB] FAIL en_off_porb got %b exp 0", porb); end
    if (por !== 1'b1) begin n_fail++; $display("[TB] FAIL en_off_por got %b exp 1", por); end
    if (otrip_decoded !== EXP_HI) begin n_fail++; $display("[TB] FAIL en_off_decoded_hold got %h exp %h", otrip_decoded, EXP_HI); end
    ena = 1'b1;
    tick();
    wait_state(3'd4, 40, ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("[TB] FAIL en_reach_released got %0d exp 4", state_o); end
    if (porb !== 1'b1) begin n_fail++; $display("[TB] FAIL en_released_porb got %b exp 1", porb); end
    #1;
    rst_n = 1'b0;
    #2;
    n_cmp += 3;
    if (porb !== 1'b0) begin n_fail++; $display("[TB] FAIL async_rst_porb got %b exp 0", porb); end
    if (por !== 1'b1) begin n_fail++; $display("[TB] FAIL async_rst_por got %b exp 1", por); end
    if (state_o !== 3'd0) begin n_fail++; $display("[TB] FAIL async_rst_state got %0d exp 0", state_o); end
    rst_n = 1'b1;
  endtask

`ifdef POR_HYST_EN
  task automatic test_hysteresis();
    bit ok;
    do_reset(3'd7);
    ena = 1'b1;
    tick();
    cmp_out = 1'b1;
    wait_state(3'd4, 40, ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("[TB] FAIL hy_reach_released got %0d exp 4", state_o); end
    if (otrip_decoded !== 8'h80) begin n_fail++; $display("[TB] FAIL hy_sat_decoded got %h exp 80", otrip_decoded); end
    do_reset(3'd2);
    ena = 1'b1;
    tick();
    n_cmp++;
    if (otrip_decoded !== 8'h04) begin n_fail++; $display("[TB] FAIL hy_armed_decoded got %h exp 04", otrip_decoded); end
    cmp_out = 1'b1;
    wait_state(3'd3, 40, ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("[TB] FAIL hy_reach_delay got %0d exp 3", state_o); end
    if (otrip_decoded !== 8'h08) begin n_fail++; $display("[TB] FAIL hy_delay_decoded got %h exp 08", otrip_decoded); end
  endtask
`endif

  // Reference: porb is high once cmp (as seen after the synchronizer) has
  // stayed high with ena for DEB+DLY+1 edges after arming.
  task automatic test_random();
    int         run;
    bit         was_off;
    logic       m_ena_r;
    logic       m_porb;
    logic [7:0] m_dec;
    logic [2:0] m_trip;
    logic [SYNC-1:0] pipe;
    logic       cs;
    do_reset(3'd0);
    run = 0;
    was_off = 1'b1;
    m_ena_r = 1'b0;
    m_porb = 1'b0;
    m_dec = 8'h00;
    m_trip = 3'd0;
    pipe = '0;
    for (int c = 0; c < 3000; c++) begin
      ena = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) cmp_out = ~cmp_out;
      if ($urandom_range(0, 9) == 0) otrip = 3'($urandom_range(0, 7));
      @(posedge clk);
      cs = pipe[SYNC-1];
      pipe = {pipe[SYNC-2:0], cmp_out};
      if (!ena) begin
        run = 0;
        was_off = 1'b1;
        m_ena_r = 1'b0;
        m_porb = 1'b0;
      end else if (was_off) begin
        run = 0;
        was_off = 1'b0;
        m_ena_r = 1'b1;
        m_porb = 1'b0;
        m_dec = 8'd1 << otrip;
        m_trip = otrip;
      end else begin
        run = cs ? ((run < 100000) ? run + 1 : run) : 0;
        if (run <= 1) begin
          m_dec = 8'd1 << otrip;
          m_trip = otrip;
        end else if (HYST && run >= DEB + 1) begin
          m_dec = 8'd1 << ((m_trip == 3'd7) ? 3'd7 : m_trip + 3'd1);
        end
        m_porb = (run >= DEB + DLY + 1);
      end
      #1;
      n_cmp += 4;
      if (porb !== m_porb) begin n_fail++; $display("[TB] FAIL rnd_porb cyc %0d got %b exp %b", c, porb, m_porb); end
      if (por !== ~m_porb) begin n_fail++; $display("[TB] FAIL rnd_por cyc %0d got %b exp %b", c, por, ~m_porb); end
      if (ena_rstring !== m_ena_r) begin n_fail++; $display("[TB] FAIL rnd_ena_rstring cyc %0d got %b exp %b", c, ena_rstring, m_ena_r); end
      if (otrip_decoded !== m_dec) begin n_fail++; $display("[TB] FAIL rnd_decoded cyc %0d got %h exp %h", c, otrip_decoded, m_dec); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    ena = 1'b0;
    otrip = 3'd0;
    cmp_out = 1'b0;
    test_reset();
    test_power_up();
    test_debounce_glitch();
    test_brownout();
    test_trip_change();
    test_enable_and_reset();
`ifdef POR_HYST_EN
    test_hysteresis();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
